// File: rtl/imm_gen_stage_if.sv
// Handshake bundle for the immediate-generation stage: decode-side push,
// execute-side pop, plus flush and occupancy.
interface imm_gen_stage_if #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 2
);
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_instr;
  logic [2:0]       in_sel;
  logic [WIDTH-1:0] in_pc;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_imm;
  logic [WIDTH-1:0] out_target;
  logic [2:0]       out_sel;
  logic             out_illegal;
  logic [CNT_W-1:0] count;

  modport master (
    output flush, in_valid, in_instr, in_sel, in_pc, out_ready,
    input  in_ready, out_valid, out_imm, out_target, out_sel, out_illegal, count
  );

  modport slave (
    input  flush, in_valid, in_instr, in_sel, in_pc, out_ready,
    output in_ready, out_valid, out_imm, out_target, out_sel, out_illegal, count
  );
endinterface

// File: rtl/imm_gen_stage.sv
// RV32I immediate generation and PC-relative target computation, buffered in
// a small in-order queue between decode and execute.
module imm_gen_stage #(
  parameter int unsigned WIDTH       = 32,
  parameter int unsigned DEPTH       = 2,
  parameter int unsigned LINK_OFFSET = 4
) (
  input  logic            clk,
  input  logic            rst,
  imm_gen_stage_if.slave  bus
);
  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  typedef struct packed {
    logic [WIDTH-1:0] imm;
    logic [WIDTH-1:0] target;
    logic [2:0]       sel;
    logic             illegal;
  } entry_t;

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  entry_t           mem_q [DEPTH];

  logic [WIDTH-1:0] imm_c;
  logic             illegal_c;
  entry_t           entry_c;
  entry_t           head_c;
  logic             in_ready_c;
  logic             out_valid_c;
  logic             push_c;
  logic             pop_c;
  logic             unused_opcode_c;

  // Opcode bits never feed an immediate.
  assign unused_opcode_c = ^bus.in_instr[6:0];

  // Immediate extraction per type select.
  always_comb begin
    imm_c     = '0;
    illegal_c = 1'b0;
    case (bus.in_sel)
      3'd0:    imm_c = WIDTH'($signed(bus.in_instr[31:20]));
      3'd1:    imm_c = WIDTH'(bus.in_instr[24:20]);
      3'd2:    imm_c = WIDTH'($signed({bus.in_instr[31:25], bus.in_instr[11:7]}));
      3'd3:    imm_c = WIDTH'($signed({bus.in_instr[31], bus.in_instr[7],
                                       bus.in_instr[30:25], bus.in_instr[11:8], 1'b0}));
      3'd4:    imm_c = WIDTH'($signed({bus.in_instr[31:12], 12'b0}));
      3'd5:    imm_c = WIDTH'($signed({bus.in_instr[31], bus.in_instr[19:12],
                                       bus.in_instr[20], bus.in_instr[30:21], 1'b0}));
      3'd6:    imm_c = WIDTH'(LINK_OFFSET);
      default: illegal_c = 1'b1;
    endcase
  end

  always_comb begin
    entry_c         = '0;
    entry_c.imm     = imm_c;
    entry_c.target  = bus.in_pc + imm_c;
    entry_c.sel     = bus.in_sel;
    entry_c.illegal = illegal_c;
  end

  assign in_ready_c  = (count_q < CNT_W'(DEPTH));
  assign out_valid_c = (count_q != '0);
  assign push_c      = bus.in_valid && in_ready_c && !bus.flush;
  assign pop_c       = out_valid_c && bus.out_ready && !bus.flush;

  // Pointer and occupancy next state; flush wins over any handshake.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (bus.flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_c) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop_c)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({push_c, pop_c})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Payload storage carries no reset; the empty mask hides stale contents.
  always_ff @(posedge clk) begin
    if (push_c) mem_q[wr_ptr_q] <= entry_c;
  end

  assign head_c = out_valid_c ? mem_q[rd_ptr_q] : '0;

  assign bus.in_ready    = in_ready_c;
  assign bus.out_valid   = out_valid_c;
  assign bus.out_imm     = head_c.imm;
  assign bus.out_target  = head_c.target;
  assign bus.out_sel     = head_c.sel;
  assign bus.out_illegal = head_c.illegal;
  assign bus.count       = count_q;

endmodule

// File: tb/tb_imm_gen_stage.sv
// Directed bench for imm_gen_stage: decode sweep, backpressure, concurrent
// push/pop, flush and asynchronous reset.
module tb_imm_gen_stage;
  localparam int unsigned WIDTH = 32;
  localparam int unsigned DEPTH = 2;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  imm_gen_stage_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

  imm_gen_stage #(.WIDTH(WIDTH), .DEPTH(DEPTH), .LINK_OFFSET(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] instr, input logic [2:0] sel,
                       input logic [31:0] pc);
    bus.in_valid = v;
    bus.in_instr = instr;
    bus.in_sel   = sel;
    bus.in_pc    = pc;
  endtask

  // Push one entry into an empty queue, check the head, then pop it.
  task automatic dec(input string tag, input logic [31:0] instr, input logic [2:0] sel,
                     input logic [31:0] exp_imm, input logic [31:0] exp_tgt,
                     input logic exp_ill);
    bus.out_ready = 1'b0;
    drive(1'b1, instr, sel, 32'h100);
    chk({tag, "_pre_valid"}, 64'(bus.out_valid), 64'd0);
    step();
    bus.in_valid = 1'b0;
    chk({tag, "_valid"}, 64'(bus.out_valid), 64'd1);
    chk({tag, "_imm"},   64'(bus.out_imm),   64'(exp_imm));
    chk({tag, "_tgt"},   64'(bus.out_target), 64'(exp_tgt));
    chk({tag, "_sel"},   64'(bus.out_sel),   64'(sel));
    chk({tag, "_ill"},   64'(bus.out_illegal), 64'(exp_ill));
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
    chk({tag, "_empty"}, 64'(bus.count), 64'd0);
    chk({tag, "_mask"},  64'(bus.out_imm), 64'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    bus.flush = 1'b0;
    bus.out_ready = 1'b0;
    drive(1'b0, 32'h0, 3'd0, 32'h0);

    // Reset state
    #12;
    chk("rst_count", 64'(bus.count), 64'd0);
    chk("rst_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_imm",   64'(bus.out_imm), 64'd0);
    step();
    rst = 1'b1;
    step();
    chk("rst_in_ready", 64'(bus.in_ready), 64'd1);

    // Decode sweep at pc=0x100
    dec("I",    32'hFFF00093, 3'd0, 32'hFFFFFFFF, 32'h000000FF, 1'b0);
    dec("SH",   32'h4030D093, 3'd1, 32'h00000003, 32'h00000103, 1'b0);
    dec("S",    32'hFE112E23, 3'd2, 32'hFFFFFFFC, 32'h000000FC, 1'b0);
    dec("U",    32'h12345037, 3'd4, 32'h12345000, 32'h12345100, 1'b0);
    dec("LINK", 32'h00000067, 3'd6, 32'h00000004, 32'h00000104, 1'b0);
    dec("B",    32'hFE000EE3, 3'd3, 32'hFFFFFFFC, 32'h000000FC, 1'b0);
    dec("J",    32'h0080006F, 3'd5, 32'h00000008, 32'h00000108, 1'b0);
    dec("ILL",  32'hFFFFFFFF, 3'd7, 32'h00000000, 32'h00000100, 1'b1);

    // Backpressure: A, B fill the queue, C is held
    bus.out_ready = 1'b0;
    drive(1'b1, 32'h00100093, 3'd0, 32'h200);
    step();
    drive(1'b1, 32'h00000000, 3'd6, 32'h300);
    step();
    chk("bp_full_ready", 64'(bus.in_ready), 64'd0);
    chk("bp_full_count", 64'(bus.count), 64'd2);
    drive(1'b1, 32'h00500013, 3'd1, 32'h400);
    step();
    chk("bp_hold_count", 64'(bus.count), 64'd2);
    chk("bp_hold_head",  64'(bus.out_imm), 64'd1);
    chk("bp_hold_tgt",   64'(bus.out_target), 64'h201);
    bus.out_ready = 1'b1;
    step();
    chk("bp_pop_a_count", 64'(bus.count), 64'd1);
    chk("bp_head_b",      64'(bus.out_imm), 64'd4);
    chk("bp_head_b_tgt",  64'(bus.out_target), 64'h304);
    step();
    bus.in_valid = 1'b0;
    chk("bp_head_c",     64'(bus.out_imm), 64'd5);
    chk("bp_head_c_tgt", 64'(bus.out_target), 64'h405);
    chk("bp_c_count",    64'(bus.count), 64'd1);
    step();
    bus.out_ready = 1'b0;
    chk("bp_drain_count", 64'(bus.count), 64'd0);
    chk("bp_drain_valid", 64'(bus.out_valid), 64'd0);

    // Concurrent push and pop at occupancy 1
    drive(1'b1, 32'h00000093, 3'd0, 32'h0);
    step();
    for (int k = 1; k <= 10; k++) begin
      drive(1'b1, {12'(k), 20'h00093}, 3'd0, 32'h0);
      bus.out_ready = 1'b1;
      step();
      chk("pp_count", 64'(bus.count), 64'd1);
      chk("pp_ready", 64'(bus.in_ready), 64'd1);
      chk("pp_head",  64'(bus.out_imm), 64'(k));
    end
    bus.in_valid = 1'b0;
    step();
    bus.out_ready = 1'b0;
    chk("pp_drain", 64'(bus.count), 64'd0);

    // Flush at full occupancy with a push pending
    drive(1'b1, 32'h00100093, 3'd0, 32'h10);
    step();
    drive(1'b1, 32'h00200093, 3'd0, 32'h20);
    step();
    chk("fl_full", 64'(bus.count), 64'd2);
    drive(1'b1, 32'h00300093, 3'd0, 32'h30);
    bus.flush = 1'b1;
    step();
    bus.flush = 1'b0;
    bus.in_valid = 1'b0;
    chk("fl_count", 64'(bus.count), 64'd0);
    chk("fl_valid", 64'(bus.out_valid), 64'd0);
    chk("fl_ready", 64'(bus.in_ready), 64'd1);
    step();
    chk("fl_dropped", 64'(bus.count), 64'd0);

    // Flush at occupancy 1 with push and pop presented together
    drive(1'b1, 32'h00400093, 3'd0, 32'h40);
    step();
    drive(1'b1, 32'h00500093, 3'd0, 32'h50);
    bus.out_ready = 1'b1;
    bus.flush = 1'b1;
    step();
    bus.flush = 1'b0;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    chk("fl1_count", 64'(bus.count), 64'd0);
    chk("fl1_valid", 64'(bus.out_valid), 64'd0);

    // Asynchronous reset between edges with an illegal entry at the head
    drive(1'b1, 32'h0, 3'd7, 32'h1234);
    step();
    drive(1'b1, 32'h00100093, 3'd0, 32'h80);
    step();
    bus.in_valid = 1'b0;
    chk("ar_pre_ill", 64'(bus.out_illegal), 64'd1);
    #2;
    rst = 1'b0;
    #1;
    chk("ar_count", 64'(bus.count), 64'd0);
    chk("ar_valid", 64'(bus.out_valid), 64'd0);
    chk("ar_imm",   64'(bus.out_imm), 64'd0);
    chk("ar_tgt",   64'(bus.out_target), 64'd0);
    chk("ar_sel",   64'(bus.out_sel), 64'd0);
    chk("ar_ill",   64'(bus.out_illegal), 64'd0);
    step();
    rst = 1'b1;
    drive(1'b1, 32'h0080006F, 3'd5, 32'h100);
    chk("ar_post_pre", 64'(bus.out_valid), 64'd0);
    step();
    bus.in_valid = 1'b0;
    chk("ar_post_count", 64'(bus.count), 64'd1);
    chk("ar_post_imm",   64'(bus.out_imm), 64'd8);
    chk("ar_post_tgt",   64'(bus.out_target), 64'h108);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/imm_gen_stage.md
Name: imm_gen_stage

Overview:
- Pipelined, parametrised immediate-generation stage for the RV32I pipeline, sitting between decode and execute.
- Extracts and sign-extends the immediate from a full 32-bit instruction word according to a 3-bit type select.
- Computes the PC-relative target (pc + imm) in the same stage.
- Buffers results in a DEPTH-entry in-order queue with valid/ready handshakes on both sides and a synchronous flush for branch redirects.

Parameters:
WIDTH, 32, datapath width of imm/pc/target; legal values >= 32; all sign extension is to WIDTH.
DEPTH, 2, queue entries; power of two, >= 2.
LINK_OFFSET, 4, constant emitted for select 6 (JALR return-address forwarding).

Ports:
clk  input  1  clock, rising edge.
rst  input  1  asynchronous reset, active-low.
flush  input  1  synchronous queue clear.
in_valid  input  1  upstream entry valid.
in_ready  output  1  stage can accept an entry.
in_instr  input  32  instruction word.
in_sel  input  3  immediate type select.
in_pc  input  WIDTH  PC of the instruction.
out_valid  output  1  head entry valid.
out_ready  input  1  downstream accepts head.
out_imm  output  WIDTH  generated immediate.
out_target  output  WIDTH  in_pc + imm, modulo 2^WIDTH.
out_sel  output  3  select that produced the entry.
out_illegal  output  1  entry was generated with select 7.
count  output  $clog2(DEPTH)+1  current occupancy.

Behaviour:
Immediate encoding per in_sel (i = in_instr); sext/zext extend to WIDTH:
- 0 I: sext(i[31:20]).
- 1 shift-amount: zext(i[24:20]).
- 2 S: sext({i[31:25], i[11:7]}).
- 3 B: sext({i[31], i[7], i[30:25], i[11:8], 1'b0}).
- 4 U: sext({i[31:12], 12'b0}).
- 5 J: sext({i[31], i[19:12], i[20], i[30:21], 1'b0}).
- 6 link: LINK_OFFSET.
- 7: imm = 0; out_illegal = 1 for that entry.

Target and latency:
- Target is computed combinationally at the input and stored with the entry; addition wraps, no overflow flag.
- Push occurs when in_valid && in_ready at a rising edge.
- Pop occurs when out_valid && out_ready at a rising edge.
- Latency: an entry pushed into an empty queue appears on out_* on the next cycle (one registered stage). There is no combinational in->out path.

Handshake rules:
- in_ready = (count < DEPTH). It does not depend on out_ready, so there is no same-cycle pass-through when full.
- out_valid = (count != 0). out_* reflect the head entry and are stable while out_valid && !out_ready.
- Simultaneous push and pop with 0 < count < DEPTH: count is unchanged and order is preserved.
- Simultaneous push and pop with count == 0: only the push happens.
- Pointers wrap modulo DEPTH. FIFO order is strict.

Flush:
- At the edge, flush empties the queue: pointers reset, count = 0.
- A push or pop presented in the same cycle is discarded.
- in_ready is 1 in the cycle after a flush.

Reset (asynchronous, active-low):
- All outputs and state are immediately cleared: count = 0, out_valid = 0, out_imm = 0, out_target = 0, out_sel = 0, out_illegal = 0, in_ready = 1 while not in reset.
- Reset asserted mid-operation discards all queued entries. No entry survives reset.

Implementation constraints:
- Storage arrays need no reset; out_* are masked to 0 when count == 0.

Test Plan:
- Decode sweep at pc=0x100:
  - sel0, 0xFFF00093 -> imm 0xFFFFFFFF, target 0xFF.
  - sel1, 0x4030D093 -> imm 3.
  - sel4, 0x12345037 -> imm 0x12345000.
  - sel6 -> imm 4, target 0x104.
- Branch/jump at pc=0x100:
  - sel3, 0xFE000EE3 -> imm 0xFFFFFFFC, target 0xFC.
  - sel5, 0x0080006F -> imm 8, target 0x108.
  - sel7 -> imm 0, out_illegal=1.
- Backpressure: out_ready=0, push A, B, C back-to-back:
  - in_ready drops after B; C is held; count=2.
  - Raise out_ready: outputs A, B, then C in order; count returns to 0.
- Simultaneous push and pop at count=1 for 10 cycles: count stays 1, no loss or duplication, in_ready stays 1.
- Flush with count=2 and in_valid=1 in the same cycle: next cycle count=0, out_valid=0, the in-flight entry is dropped, in_ready=1.
- Async reset asserted mid-stream between clock edges: outputs go to 0 immediately. After release, the first push appears one cycle later with the correct imm.
